pwm_ramp_sequencer: RTL and testbench

// Front-end controller for the 8-bit PWM duty register: debounces the up/down push-keys,

---
 rtl/pwm_ramp_sequencer.sv | 169 ++++++++++++++++
 tb/tb_pwm_ramp_sequencer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_ramp_sequencer.sv
// Purpose: debounced up/down keys set a saturating target duty; live duty slews one LSB per RAMP cycles.
// Latency: raw key edge to target change DEB+3 cycles; first duty step RAMP cycles after leaving IDLE.
// Backpressure: none; duty_vld is a 1-cycle load strobe the PWM core must accept every time it fires.
module pwm_ramp_sequencer #(
   parameter logic [31:0] DEB    = 32'd500000,
   parameter logic [31:0] REPEAT = 32'd5000000,
   parameter logic [31:0] RAMP   = 32'd10000,
   parameter logic [7:0]  STEP   = 8'd16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       up,
   input  logic       down,
   input  logic       estop,
   output logic [7:0] duty,
   output logic       duty_vld,
   output logic       busy,
   output logic [7:0] state
);

   typedef enum logic [1:0] {S_IDLE, S_UP, S_DOWN} fsm_t;

   // Key bit 0 is up, bit 1 is down; all key signals are active-low.
   logic [1:0]  raw;
   logic [1:0]  sync1;
   logic [1:0]  sync2;
   logic [1:0]  deb;
   logic [1:0]  deb_d1;
   logic [31:0] deb_cnt [2];
   logic [31:0] rep_cnt [2];
   logic [1:0]  held;
   logic [1:0]  press;
   logic [1:0]  rep_fire;
   logic [1:0]  key_ev;

   fsm_t        fsm;
   logic [7:0]  target;
   logic [7:0]  target_nx;
   logic [31:0] tick_cnt;
   logic [8:0]  tgt_sum;
   logic [8:0]  tgt_dif;

   assign raw = {down, up};

   // Two-stage synchronizer, then a level debouncer that needs DEB consecutive differing samples.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1  <= 2'b11;
         sync2  <= 2'b11;
         deb    <= 2'b11;
         deb_d1 <= 2'b11;
         for (int k = 0; k < 2; k++) begin
            deb_cnt[k] <= '0;
         end
      end else begin
         sync1  <= raw;
         sync2  <= sync1;
         deb_d1 <= deb;
         for (int k = 0; k < 2; k++) begin
            if (sync2[k] != deb[k]) begin
               if (deb_cnt[k] == DEB - 32'd1) begin
                  deb[k]     <= sync2[k];
                  deb_cnt[k] <= '0;
               end else begin
                  deb_cnt[k] <= deb_cnt[k] + 32'd1;
               end
            end else begin
               deb_cnt[k] <= '0;
            end
         end
      end
   end

   // A key only produces events while it is the sole debounced-pressed key, so
   // simultaneous presses (or one press landing while the other is held) are dropped.
   assign held[0]     = ~deb[0] & deb[1];
   assign held[1]     = ~deb[1] & deb[0];
   assign press[0]    = deb_d1[0] & held[0];
   assign press[1]    = deb_d1[1] & held[1];
   assign rep_fire[0] = held[0] & ~press[0] & (rep_cnt[0] == REPEAT - 32'd1);
   assign rep_fire[1] = held[1] & ~press[1] & (rep_cnt[1] == REPEAT - 32'd1);
   assign key_ev      = press | rep_fire;

   // Auto-repeat counters: cycles since this key's last event while held alone.
   always_ff @(posedge clk) begin
      if (rst || estop) begin
         for (int k = 0; k < 2; k++) begin
            rep_cnt[k] <= '0;
         end
      end else begin
         for (int k = 0; k < 2; k++) begin
            if (!held[k] || key_ev[k]) begin
               rep_cnt[k] <= '0;
            end else begin
               rep_cnt[k] <= rep_cnt[k] + 32'd1;
            end
         end
      end
   end

   // Saturating target arithmetic in 9 bits: bit 8 flags overflow on add, borrow on subtract.
   assign tgt_sum = {1'b0, target} + {1'b0, STEP};
   assign tgt_dif = {1'b0, target} - {1'b0, STEP};

   // Next target from this cycle's key event, if any.
   always_comb begin
      target_nx = target;
      if (key_ev[0]) begin
         target_nx = tgt_sum[8] ? 8'hFF : tgt_sum[7:0];
      end else if (key_ev[1]) begin
         target_nx = tgt_dif[8] ? 8'h00 : tgt_dif[7:0];
      end
   end

   // Ramp FSM: direction re-evaluated every cycle, tick counter survives UP<->DOWN reversals.
   always_ff @(posedge clk) begin
      if (rst) begin
         fsm      <= S_IDLE;
         duty     <= 8'h00;
         target   <= 8'h00;
         duty_vld <= 1'b0;
         busy     <= 1'b0;
         tick_cnt <= '0;
      end else if (estop) begin
         fsm      <= S_IDLE;
         duty     <= 8'h00;
         target   <= 8'h00;
         duty_vld <= (duty != 8'h00);
         busy     <= 1'b0;
         tick_cnt <= '0;
      end else begin
         target   <= target_nx;
         duty_vld <= 1'b0;
         case (fsm)
            S_IDLE: begin
               tick_cnt <= '0;
               if (duty < target) begin
                  fsm  <= S_UP;
                  busy <= 1'b1;
               end else if (duty > target) begin
                  fsm  <= S_DOWN;
                  busy <= 1'b1;
               end
            end
            default: begin
               if (duty == target) begin
                  fsm      <= S_IDLE;
                  busy     <= 1'b0;
                  tick_cnt <= '0;
               end else begin
                  fsm  <= (duty < target) ? S_UP : S_DOWN;
                  busy <= 1'b1;
                  if (tick_cnt == RAMP - 32'd1) begin
                     tick_cnt <= '0;
                     duty_vld <= 1'b1;
                     duty     <= (duty < target) ? duty + 8'd1 : duty - 8'd1;
                  end else begin
                     tick_cnt <= tick_cnt + 32'd1;
                  end
               end
            end
         endcase
      end
   end

   // Inverted target drives active-low LEDs.
   assign state = ~target;

endmodule

// File: tb/tb_pwm_ramp_sequencer.sv
module tb_pwm_ramp_sequencer;
   localparam int DEB    = 4;
   localparam int REPEAT = 20;
   localparam int RAMP   = 3;
   localparam int STEP   = 16;

   logic       clk = 1'b0;
   logic       rst, up, down, estop;
   logic [7:0] duty, state;
   logic       duty_vld, busy;

   pwm_ramp_sequencer #(
      .DEB(32'd4), .REPEAT(32'd20), .RAMP(32'd3), .STEP(8'd16)
   ) dut (
      .clk(clk), .rst(rst), .up(up), .down(down), .estop(estop),
      .duty(duty), .duty_vld(duty_vld), .busy(busy), .state(state)
   );

   always #5 clk = ~clk;

   int         n_tests = 0;
   int         n_fail  = 0;
   int         vld_cnt = 0;
   bit         saw_down = 0;
   logic [7:0] prev_duty = 8'h00;

   // Reference model: keys as delayed raw samples plus a sample window; ramp as plain arithmetic.
   bit             m_dly [2][2];
   logic [DEB-1:0] m_win [2];
   bit             m_deb [2];
   bit             m_fell [2];
   int             m_age [2];
   int             m_duty, m_target, m_phase;
   bit             m_busy, m_vld;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_edge();
      bit raw [2];
      bit held [2];
      bit ev [2];
      bit s;
      int nt;
      raw[0] = up;
      raw[1] = down;
      for (int k = 0; k < 2; k++) begin
         held[k] = !m_deb[k] && m_deb[1-k];
         ev[k]   = (m_fell[k] && m_deb[1-k]) || (held[k] && (m_age[k] + 1 == REPEAT));
      end
      if (rst) begin
         for (int k = 0; k < 2; k++) begin
            m_dly[k][0] = 1'b1;
            m_dly[k][1] = 1'b1;
            m_win[k]    = '1;
            m_deb[k]    = 1'b1;
            m_fell[k]   = 1'b0;
            m_age[k]    = 0;
         end
         m_duty = 0; m_target = 0; m_phase = 0; m_busy = 0; m_vld = 0;
         return;
      end
      for (int k = 0; k < 2; k++) begin
         s           = m_dly[k][1];
         m_dly[k][1] = m_dly[k][0];
         m_dly[k][0] = raw[k];
         m_win[k]    = {m_win[k][DEB-2:0], s};
         m_fell[k]   = 1'b0;
         if (m_deb[k] && m_win[k] == '0) begin
            m_deb[k]  = 1'b0;
            m_fell[k] = 1'b1;
         end else if (!m_deb[k] && m_win[k] == '1) begin
            m_deb[k] = 1'b1;
         end
         m_age[k] = (estop || !held[k] || ev[k]) ? 0 : m_age[k] + 1;
      end
      if (estop) begin
         m_vld = (m_duty != 0);
         m_duty = 0; m_target = 0; m_busy = 0; m_phase = 0;
         return;
      end
      nt = m_target;
      if (ev[0])      nt = (m_target + STEP > 255) ? 255 : m_target + STEP;
      else if (ev[1]) nt = (m_target < STEP) ? 0 : m_target - STEP;
      m_vld = 0;
      if (!m_busy) begin
         m_phase = 0;
         m_busy  = (m_duty != m_target);
      end else if (m_duty == m_target) begin
         m_busy  = 0;
         m_phase = 0;
      end else begin
         m_phase++;
         if (m_phase == RAMP) begin
            m_phase = 0;
            m_vld   = 1;
            m_duty  = (m_duty < m_target) ? m_duty + 1 : m_duty - 1;
         end
      end
      m_target = nt;
   endtask

   task automatic tick();
      logic [7:0] exp_state;
      @(posedge clk);
      model_edge();
      @(negedge clk);
      exp_state = ~m_target[7:0];
      chk("duty", duty, m_duty);
      chk("duty_vld", duty_vld, m_vld);
      chk("busy", busy, m_busy);
      chk("state", state, exp_state);
      if (duty_vld === 1'b1) begin
         vld_cnt++;
         if (duty < prev_duty) saw_down = 1;
      end
      prev_duty = duty;
   endtask

   task automatic press(input int key, input int lo, input int hi);
      if (key == 0) up = 1'b0; else down = 1'b0;
      repeat (lo) tick();
      if (key == 0) up = 1'b1; else down = 1'b1;
      repeat (hi) tick();
   endtask

   task automatic wait_idle(input string tag, input int bound);
      bit done;
      done = 0;
      for (int i = 0; i < bound && !done; i++) begin
         tick();
         if (busy === 1'b0 && duty === ~state) done = 1;
      end
      chk(tag, done, 1);
   endtask

   task automatic wait_duty(input string tag, input logic [7:0] val, input int bound);
      bit done;
      done = 0;
      for (int i = 0; i < bound && !done; i++) begin
         tick();
         if (duty === val) done = 1;
      end
      chk(tag, done, 1);
   endtask

   initial begin
      int lat;
      int r;
      int a;
      int b;
      rst = 1'b1; up = 1'b1; down = 1'b1; estop = 1'b0;

      // Reset values
      tick(); tick();
      chk("rst_duty", duty, 8'h00);
      chk("rst_state", state, 8'hFF);
      chk("rst_vld", duty_vld, 1'b0);
      chk("rst_busy", busy, 1'b0);
      rst = 1'b0;
      tick();

      // Single press: latency DEB+3, ramp to 16 with 16 strobes
      vld_cnt = 0; lat = 0;
      up = 1'b0;
      for (int i = 1; i <= 12; i++) begin
         tick();
         if (lat == 0 && state !== 8'hFF) lat = i;
      end
      up = 1'b1;
      chk("key_latency", lat, DEB + 3);
      wait_idle("ramp16_idle", 100);
      chk("ramp16_duty", duty, 8'd16);
      chk("ramp16_state", state, 8'hEF);
      chk("ramp16_pulses", vld_cnt, 16);

      // Glitch rejected, then held key auto-repeats twice
      vld_cnt = 0;
      up = 1'b0; tick(); tick(); up = 1'b1;
      repeat (15) tick();
      chk("glitch_state", state, 8'hEF);
      chk("glitch_vld", vld_cnt, 0);
      up = 1'b0; repeat (60) tick(); up = 1'b1;
      wait_idle("repeat_idle", 300);
      chk("repeat_state", state, 8'hBF);
      chk("repeat_duty", duty, 8'd64);

      // Saturation at the top and at zero
      up = 1'b0; repeat (210) tick(); up = 1'b1; repeat (10) tick();
      chk("t240_state", state, 8'h0F);
      press(0, 6, 10);
      chk("t255_state", state, 8'h00);
      down = 1'b0; repeat (340) tick(); down = 1'b1;
      wait_idle("down_idle", 1200);
      chk("zero_duty", duty, 8'h00);
      chk("zero_state", state, 8'hFF);
      vld_cnt = 0;
      down = 1'b0;
      repeat (8) begin tick(); chk("sat_busy", busy, 1'b0); end
      down = 1'b1;
      repeat (12) begin tick(); chk("sat_busy", busy, 1'b0); end
      chk("sat_vld", vld_cnt, 0);
      chk("sat_state", state, 8'hFF);

      // Reversal mid-ramp
      saw_down = 0;
      repeat (4) press(0, 6, 6);
      wait_duty("rev_duty20", 8'd20, 200);
      repeat (3) press(1, 6, 6);
      chk("rev_state", state, 8'hEF);
      wait_idle("rev_idle", 300);
      chk("rev_duty", duty, 8'd16);
      chk("rev_saw_down", saw_down, 1);

      // Emergency stop
      repeat (3) press(0, 6, 6);
      wait_duty("estop_duty40", 8'd40, 300);
      estop = 1'b1; tick(); estop = 1'b0;
      chk("estop_duty", duty, 8'h00);
      chk("estop_vld", duty_vld, 1'b1);
      chk("estop_busy", busy, 1'b0);
      chk("estop_state", state, 8'hFF);
      tick();
      chk("estop_vld_once", duty_vld, 1'b0);

      // Reset mid-ramp, with estop also high
      repeat (3) press(0, 6, 6);
      wait_duty("rst_duty40", 8'd40, 300);
      rst = 1'b1; estop = 1'b1; tick(); rst = 1'b0; estop = 1'b0;
      chk("rst2_duty", duty, 8'h00);
      chk("rst2_vld", duty_vld, 1'b0);
      chk("rst2_busy", busy, 1'b0);
      chk("rst2_state", state, 8'hFF);

      // Randomized traffic against the model
      for (int it = 0; it < 80; it++) begin
         r = $urandom_range(0, 19);
         a = $urandom_range(1, 45);
         b = $urandom_range(1, 12);
         if (r < 7) begin
            press(0, a, b);
         end else if (r < 14) begin
            press(1, a, b);
         end else if (r < 16) begin
            up = 1'b0; down = 1'b0;
            repeat (a) tick();
            up = 1'b1; down = 1'b1;
            repeat (b) tick();
         end else if (r < 18) begin
            estop = 1'b1; repeat ($urandom_range(1, 3)) tick(); estop = 1'b0;
         end else if (r == 18) begin
            rst = 1'b1; tick(); rst = 1'b0;
         end else begin
            repeat (a) tick();
         end
      end
      repeat (50) tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
